if_prefetch_stage: RTL and testbench



---
 rtl/if_prefetch_stage_pkg.sv | 15 +
 rtl/if_prefetch_stage_if.sv | 51 +++++
 rtl/if_prefetch_stage_fetch_queue.sv | 96 +++++++++
 rtl/if_prefetch_stage.sv | 116 +++++++++++
 tb/tb_if_prefetch_stage.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/if_prefetch_stage_pkg.sv
// Purpose  : shared constants and helpers for the fetch stage (NOP/HALT encodings, word size, index width).
// Latency  : n/a (package only).
// Backpress: n/a.
package if_pkg;

   localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
   localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;
   localparam int unsigned WORD_BYTES = 4;

   // Bits needed to index n entries; never below 1 so slices stay legal.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/if_prefetch_stage_if.sv
// Purpose  : bundle of the fetch stage's control, redirect, debug-load and IF/ID head signals.
// Latency  : n/a (wiring only); slave = fetch stage, master = surrounding pipeline / debug unit.
// Backpress: i_pc_write is the consumer ready, i_step the global advance enable.
// Optional : IF_HALT_DETECT_EN adds o_halt_fetched.
interface if_prefetch_stage_if #(
   parameter int NB    = 32,
   parameter int DEPTH = 4
);
   import if_pkg::*;

   localparam int CW = idx_width(DEPTH) + 1;

   logic          i_step;
   logic          i_pc_write;
   logic          i_branch;
   logic [NB-1:0] i_branch_addr;
   logic          i_jump;
   logic [NB-1:0] i_jump_addr;
   logic          i_instruction_write_enable;
   logic [NB-1:0] i_instruction_address;
   logic [NB-1:0] i_instruction_data;
   logic [NB-1:0] o_IF_pc;
   logic [NB-1:0] o_IF_pc4;
   logic [NB-1:0] o_IF_pc8;
   logic [NB-1:0] o_instruction;
   logic          o_valid;
   logic [NB-1:0] o_fetch_pc;
   logic [CW-1:0] o_count;
`ifdef IF_HALT_DETECT_EN
   logic          o_halt_fetched;
`endif

   modport master (
      output i_step, i_pc_write, i_branch, i_branch_addr, i_jump, i_jump_addr,
      output i_instruction_write_enable, i_instruction_address, i_instruction_data,
      input  o_IF_pc, o_IF_pc4, o_IF_pc8, o_instruction, o_valid, o_fetch_pc, o_count
`ifdef IF_HALT_DETECT_EN
      , input o_halt_fetched
`endif
   );

   modport slave (
      input  i_step, i_pc_write, i_branch, i_branch_addr, i_jump, i_jump_addr,
      input  i_instruction_write_enable, i_instruction_address, i_instruction_data,
      output o_IF_pc, o_IF_pc4, o_IF_pc8, o_instruction, o_valid, o_fetch_pc, o_count
`ifdef IF_HALT_DETECT_EN
      , output o_halt_fetched
`endif
   );

endinterface

// File: rtl/if_prefetch_stage_fetch_queue.sv
// Purpose  : DEPTH-entry FIFO of {pc, instr} with flush; head pc/instr held in registers.
// Latency  : push to head visible 1 cycle later; pop/flush take effect at the clock edge.
// Backpress: caller must not push when full unless popping; flush overrides push and pop.
// Ports    : i_push/i_push_pc/i_push_instr enqueue, i_pop dequeue, i_flush empty;
//            o_head_pc/o_head_instr/o_valid/o_count describe the head and occupancy.
module fetch_queue
   import if_pkg::*;
#(
   parameter  int NB    = 32,
   parameter  int DEPTH = 4,
   localparam int PW    = idx_width(DEPTH),
   localparam int CW    = PW + 1
)(
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_push,
   input  logic [NB-1:0] i_push_pc,
   input  logic [NB-1:0] i_push_instr,
   input  logic          i_pop,
   input  logic          i_flush,
   output logic [NB-1:0] o_head_pc,
   output logic [NB-1:0] o_head_instr,
   output logic          o_valid,
   output logic [CW-1:0] o_count
);

   typedef struct packed {
      logic [NB-1:0] pc;
      logic [NB-1:0] instr;
   } entry_t;

   entry_t        r_slot [DEPTH];
   entry_t        r_head;
   logic [PW-1:0] r_rd_ptr;
   logic [PW-1:0] r_wr_ptr;
   logic [CW-1:0] r_count;

   logic          w_do_pop;
   logic          w_do_push;
   logic [CW-1:0] w_remain;
   logic [CW-1:0] w_next_count;
   logic [PW-1:0] w_next_rd;
   entry_t        w_next_head;

   assign w_do_pop  = i_pop & (r_count != '0) & ~i_flush;
   assign w_do_push = i_push & ~i_flush;
   assign w_remain  = r_count - CW'(w_do_pop);

   always_comb begin
      w_next_count = i_flush ? '0 : (w_remain + CW'(w_do_push));
      w_next_rd    = r_rd_ptr + PW'(w_do_pop);
      w_next_head  = r_head;
      if (w_next_count == '0) begin
         // Empty: keep the last head pc visible, show a NOP.
         w_next_head.instr = NB'(NOP_INSTR);
      end else if (w_remain == '0) begin
         // Queue was (or became) empty this cycle, so the pushed word is the new head.
         w_next_head.pc    = i_push_pc;
         w_next_head.instr = i_push_instr;
      end else begin
         w_next_head = r_slot[w_next_rd];
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_do_push) begin
         r_slot[r_wr_ptr] <= '{pc: i_push_pc, instr: i_push_instr};
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_rd_ptr     <= '0;
         r_wr_ptr     <= '0;
         r_count      <= '0;
         r_head.pc    <= '0;
         r_head.instr <= NB'(NOP_INSTR);
      end else begin
         if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
         end else begin
            r_rd_ptr <= w_next_rd;
            r_wr_ptr <= r_wr_ptr + PW'(w_do_push);
         end
         r_count <= w_next_count;
         r_head  <= w_next_head;
      end
   end

   assign o_head_pc    = r_head.pc;
   assign o_head_instr = r_head.instr;
   assign o_valid      = (r_count != '0);
   assign o_count      = r_count;

endmodule

// File: rtl/if_prefetch_stage.sv
// Purpose  : MIPS fetch stage: fetch PC, debug-loadable instruction memory, prefetch queue to IF/ID.
// Latency  : 1 step from reset/redirect to o_valid; 1 instruction per step steady state.
// Backpress: i_pc_write=0 stalls the head; fetch continues until the queue is full; i_step=0 freezes all but debug writes.
// Ports    : i_clk, i_reset (sync, active-high); io_bus (slave) carries step/consumer/redirect/debug inputs
//            and the head pc/pc4/pc8/instruction, valid, fetch pc and occupancy outputs.
// Optional : IF_HALT_DETECT_EN stops fetching after a HALT word is queued and raises o_halt_fetched.
module if_prefetch_stage
   import if_pkg::*;
#(
   parameter int NB    = 32,
   parameter int TAM_I = 256,
   parameter int DEPTH = 4
)(
   input  logic                i_clk,
   input  logic                i_reset,
   if_prefetch_stage_if.slave  io_bus
);

   localparam int IW = idx_width(TAM_I);
   localparam int CW = idx_width(DEPTH) + 1;

   logic [NB-1:0] r_imem [TAM_I];
   logic [NB-1:0] r_fetch_pc;

   logic [IW-1:0] w_rd_idx;
   logic [IW-1:0] w_wr_idx;
   logic [NB-1:0] w_fetch_instr;
   logic          w_redirect;
   logic [NB-1:0] w_target;
   logic          w_pop;
   logic          w_push;
   logic          w_halted;
   logic          w_valid;
   logic [CW-1:0] w_count;
   logic [NB-1:0] w_head_pc;
   logic [NB-1:0] w_head_instr;
   logic [NB-1:0] w_unused_addr_bits;

   // Word index only; byte offset and bits above the memory size are dropped.
   assign w_rd_idx      = r_fetch_pc[IW+1:2];
   assign w_wr_idx      = io_bus.i_instruction_address[IW+1:2];
   assign w_fetch_instr = r_imem[w_rd_idx];
   assign w_unused_addr_bits = {r_fetch_pc[NB-1:IW+2], r_fetch_pc[1:0],
                                io_bus.i_instruction_address[NB-1:IW+2],
                                io_bus.i_instruction_address[1:0]}
                             ^ {NB{1'b0}};

   assign w_redirect = io_bus.i_step & (io_bus.i_jump | io_bus.i_branch);
   assign w_target   = io_bus.i_jump ? io_bus.i_jump_addr : io_bus.i_branch_addr;
   assign w_pop      = io_bus.i_step & io_bus.i_pc_write & w_valid;
   // A full queue still accepts a push when the head leaves in the same step.
   assign w_push     = io_bus.i_step & ~w_redirect & ~w_halted &
                       ((w_count < CW'(DEPTH)) | w_pop);

   // Debug loads ignore i_step and reset so a program survives both.
   always_ff @(posedge i_clk) begin
      if (io_bus.i_instruction_write_enable) begin
         r_imem[w_wr_idx] <= io_bus.i_instruction_data;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_fetch_pc <= '0;
      end else if (w_redirect) begin
         r_fetch_pc <= w_target;
      end else if (w_push) begin
         r_fetch_pc <= r_fetch_pc + NB'(WORD_BYTES);
      end
   end

`ifdef IF_HALT_DETECT_EN
   logic r_halt;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_halt <= 1'b0;
      end else if (w_redirect) begin
         r_halt <= 1'b0;
      end else if (w_push && (w_fetch_instr == NB'(HALT_INSTR))) begin
         r_halt <= 1'b1;
      end
   end

   assign w_halted              = r_halt;
   assign io_bus.o_halt_fetched = r_halt;
`else
   assign w_halted = 1'b0;
`endif

   fetch_queue #(
      .NB    (NB),
      .DEPTH (DEPTH)
   ) u_fetch_queue (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_push       (w_push),
      .i_push_pc    (r_fetch_pc),
      .i_push_instr (w_fetch_instr),
      .i_pop        (w_pop),
      .i_flush      (w_redirect),
      .o_head_pc    (w_head_pc),
      .o_head_instr (w_head_instr),
      .o_valid      (w_valid),
      .o_count      (w_count)
   );

   assign io_bus.o_IF_pc       = w_head_pc;
   assign io_bus.o_IF_pc4      = w_head_pc + NB'(WORD_BYTES);
   assign io_bus.o_IF_pc8      = w_head_pc + NB'(2 * WORD_BYTES);
   assign io_bus.o_instruction = w_head_instr;
   assign io_bus.o_valid       = w_valid;
   assign io_bus.o_fetch_pc    = r_fetch_pc;
   assign io_bus.o_count       = w_count;

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Purpose  : self-checking bench for if_prefetch_stage: directed scenarios plus randomized traffic.
// Latency  : outputs compared every cycle on the falling edge against a queue-based model.
// Backpress: random i_step / i_pc_write stalls, redirects, debug writes and resets.
module tb_if_prefetch_stage;
   import if_pkg::*;

   localparam int NB    = 32;
   localparam int TAM_I = 256;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst;

   if_prefetch_stage_if #(.NB(NB), .DEPTH(DEPTH)) bus();

   if_prefetch_stage #(.NB(NB), .TAM_I(TAM_I), .DEPTH(DEPTH)) dut (
      .i_clk   (clk),
      .i_reset (rst),
      .io_bus  (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } ent_t;

   ent_t        mq[$];
   logic [31:0] mmem [TAM_I];
   logic [31:0] m_fetch = 0;
   logic [31:0] m_last  = 0;
   bit          m_halt  = 0;
   bit          m_chk   = 0;

   task automatic model_edge();
      bit   do_pop;
      bit   do_push;
      ent_t e;
      if (rst) begin
         mq.delete();
         m_fetch = 0;
         m_last  = 0;
         m_halt  = 0;
         m_chk   = 1;
      end else if (bus.i_step) begin
         if (bus.i_jump || bus.i_branch) begin
            mq.delete();
            m_fetch = bus.i_jump ? bus.i_jump_addr : bus.i_branch_addr;
            m_halt  = 0;
         end else begin
            do_pop  = bus.i_pc_write && (mq.size() > 0);
            do_push = !m_halt && ((mq.size() < DEPTH) || do_pop);
            if (do_pop) void'(mq.pop_front());
            if (do_push) begin
               e.pc    = m_fetch;
               e.instr = mmem[(m_fetch >> 2) % TAM_I];
               mq.push_back(e);
`ifdef IF_HALT_DETECT_EN
               if (e.instr == 32'hFFFF_FFFF) m_halt = 1;
`endif
               m_fetch = m_fetch + 4;
            end
         end
      end
      if (mq.size() > 0) m_last = mq[0].pc;
      if (bus.i_instruction_write_enable)
         mmem[(bus.i_instruction_address >> 2) % TAM_I] = bus.i_instruction_data;
   endtask

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (m_chk) begin
         logic [31:0] e_pc;
         logic [31:0] e_ins;
         e_pc  = (mq.size() > 0) ? mq[0].pc    : m_last;
         e_ins = (mq.size() > 0) ? mq[0].instr : 32'h0;
         check("valid",    32'(bus.o_valid), 32'(mq.size() > 0));
         check("count",    32'(bus.o_count), 32'(mq.size()));
         check("IF_pc",    bus.o_IF_pc,      e_pc);
         check("IF_pc4",   bus.o_IF_pc4,     e_pc + 4);
         check("IF_pc8",   bus.o_IF_pc8,     e_pc + 8);
         check("instr",    bus.o_instruction, e_ins);
         check("fetch_pc", bus.o_fetch_pc,   m_fetch);
`ifdef IF_HALT_DETECT_EN
         check("halt",     32'(bus.o_halt_fetched), 32'(m_halt));
`endif
      end
   end

   task automatic cyc();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      #1;
   endtask

   task automatic idle();
      bus.i_step = 0; bus.i_pc_write = 0; bus.i_branch = 0; bus.i_jump = 0;
      bus.i_branch_addr = 0; bus.i_jump_addr = 0;
      bus.i_instruction_write_enable = 0;
      bus.i_instruction_address = 0; bus.i_instruction_data = 0;
   endtask

   function automatic logic [31:0] pick_target();
      case ($urandom_range(0, 3))
         0: return 32'($urandom_range(0, 1023)) & ~32'h3;
         1: return 32'($urandom_range(0, 1023));
         2: return 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      idle();
      rst = 1;
      cyc();
      rst = 0;

      // Load the whole memory; words 0..2 carry the known program.
      for (int i = 0; i < TAM_I; i++) begin
         bus.i_instruction_write_enable = 1;
         bus.i_instruction_address = 32'(i * 4);
         bus.i_instruction_data = (i < 3) ? 32'((i + 1) * 32'h11) : ($urandom & 32'h7FFF_FFFF);
         cyc();
      end
      idle();

      // Reset state, then three popping steps.
      rst = 1; cyc(); rst = 0;
      check("rst_valid", 32'(bus.o_valid), 0);
      check("rst_count", 32'(bus.o_count), 0);
      check("rst_pc",    bus.o_IF_pc, 0);
      check("rst_pc4",   bus.o_IF_pc4, 4);
      check("rst_pc8",   bus.o_IF_pc8, 8);
      check("rst_instr", bus.o_instruction, 0);
      check("rst_fetch", bus.o_fetch_pc, 0);
      bus.i_step = 1; bus.i_pc_write = 1;
      cyc(); check("s1_pc", bus.o_IF_pc, 0); check("s1_ins", bus.o_instruction, 32'h11);
      cyc(); check("s2_pc", bus.o_IF_pc, 4); check("s2_ins", bus.o_instruction, 32'h22);
      cyc(); check("s3_pc", bus.o_IF_pc, 8); check("s3_ins", bus.o_instruction, 32'h33);
      check("s3_pc8", bus.o_IF_pc8, 16);

      // Stalled consumer: occupancy saturates, then push+pop keeps it full.
      rst = 1; bus.i_step = 0; cyc(); rst = 0;
      bus.i_step = 1; bus.i_pc_write = 0;
      repeat (6) cyc();
      check("full_count", 32'(bus.o_count), 4);
      check("full_fetch", bus.o_fetch_pc, 16);
      bus.i_pc_write = 1; cyc();
      check("pp_count", 32'(bus.o_count), 4);
      check("pp_fetch", bus.o_fetch_pc, 20);
      check("pp_pc",    bus.o_IF_pc, 4);

      // Jump and branch together: jump wins, queue flushed.
      bus.i_branch = 1; bus.i_branch_addr = 32'h40;
      bus.i_jump = 1;   bus.i_jump_addr = 32'h80;
      cyc();
      check("rd_count", 32'(bus.o_count), 0);
      check("rd_valid", 32'(bus.o_valid), 0);
      check("rd_fetch", bus.o_fetch_pc, 32'h80);
      bus.i_branch = 0; bus.i_jump = 0;
      cyc();
      check("rd_head", bus.o_IF_pc, 32'h80);
      check("rd_v1",   32'(bus.o_valid), 1);

      // Frozen pipeline; a debug write in the window is seen later.
      bus.i_step = 0; bus.i_jump = 1; bus.i_branch = 1; bus.i_jump_addr = 32'h200;
      for (int i = 0; i < 5; i++) begin
         bus.i_instruction_write_enable = (i == 0);
         bus.i_instruction_address = 32'h88;
         bus.i_instruction_data = 32'hABCD_1234;
         cyc();
      end
      bus.i_instruction_write_enable = 0;
      check("frz_count", 32'(bus.o_count), 1);
      check("frz_pc",    bus.o_IF_pc, 32'h80);
      check("frz_fetch", bus.o_fetch_pc, 32'h84);
      bus.i_step = 1; bus.i_jump = 0; bus.i_branch = 0; bus.i_pc_write = 1;
      cyc(); cyc();
      check("dbg_pc",  bus.o_IF_pc, 32'h88);
      check("dbg_ins", bus.o_instruction, 32'hABCD_1234);

      // Memory index wrap: pc 0x400 reads word 0.
      bus.i_jump = 1; bus.i_jump_addr = 32'h3FC; cyc(); bus.i_jump = 0;
      cyc(); check("mw_pc0", bus.o_IF_pc, 32'h3FC);
      cyc(); check("mw_pc1", bus.o_IF_pc, 32'h400); check("mw_ins", bus.o_instruction, 32'h11);

      // Address-space wrap of the fetch pc.
      bus.i_jump = 1; bus.i_jump_addr = 32'hFFFF_FFFC; cyc(); bus.i_jump = 0;
      cyc(); cyc();
      check("aw_pc",  bus.o_IF_pc, 32'h0);
      check("aw_ins", bus.o_instruction, 32'h11);

`ifdef IF_HALT_DETECT_EN
      bus.i_step = 0; bus.i_instruction_write_enable = 1;
      bus.i_instruction_address = 32'h8; bus.i_instruction_data = 32'hFFFF_FFFF;
      cyc();
      bus.i_instruction_write_enable = 0;
      bus.i_step = 1; bus.i_pc_write = 0; bus.i_jump = 1; bus.i_jump_addr = 0; cyc();
      bus.i_jump = 0;
      repeat (5) cyc();
      check("h_flag",  32'(bus.o_halt_fetched), 1);
      check("h_fetch", bus.o_fetch_pc, 32'hC);
      check("h_count", 32'(bus.o_count), 3);
      bus.i_pc_write = 1;
      repeat (6) cyc();
      check("h_drain", 32'(bus.o_valid), 0);
      check("h_fetch2", bus.o_fetch_pc, 32'hC);
      bus.i_jump = 1; bus.i_jump_addr = 0; cyc(); bus.i_jump = 0;
      check("h_clear", 32'(bus.o_halt_fetched), 0);
`endif

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         rst           = ($urandom_range(0, 199) == 0);
         bus.i_step    = ($urandom_range(0, 3) != 0);
         bus.i_pc_write = ($urandom_range(0, 4) < 3);
         bus.i_jump    = ($urandom_range(0, 29) == 0);
         bus.i_branch  = ($urandom_range(0, 19) == 0);
         bus.i_jump_addr   = pick_target();
         bus.i_branch_addr = pick_target();
         bus.i_instruction_write_enable = ($urandom_range(0, 9) == 0);
         bus.i_instruction_address = $urandom;
         bus.i_instruction_data = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
         cyc();
      end
      rst = 0;
      idle();
      cyc();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
